// File: rtl/bcd_up_counter_2digit.sv
// rtl/bcd_up_counter_2digit.sv - two-digit BCD up counter with load, wrap at TERMINAL and carry pulse
module bcd_up_counter_2digit #(
    parameter int TERMINAL = 99
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       enable,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       carry,
    output logic       load_err
);

    localparam logic [7:0] TERM = 8'(TERMINAL);

    logic [3:0] ld_tens;
    logic [3:0] ld_ones;
    logic       ld_tens_bad;
    logic       ld_ones_bad;
    logic [7:0] count_val;
    logic       at_terminal;

    assign ld_tens_bad = (load_value[7:4] > 4'd9);
    assign ld_ones_bad = (load_value[3:0] > 4'd9);
    assign ld_tens     = ld_tens_bad ? 4'd0 : load_value[7:4];
    assign ld_ones     = ld_ones_bad ? 4'd0 : load_value[3:0];

    // Decimal value of the current count; a loaded value above TERMINAL also wraps.
    assign count_val   = ({4'd0, tens} * 8'd10) + {4'd0, ones};
    assign at_terminal = (count_val >= TERM);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            ones     <= 4'd0;
            tens     <= 4'd0;
            carry    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            carry    <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                tens     <= ld_tens;
                ones     <= ld_ones;
                load_err <= ld_tens_bad | ld_ones_bad;
            end else if (enable) begin
                if (at_terminal) begin
                    tens  <= 4'd0;
                    ones  <= 4'd0;
                    carry <= 1'b1;
                end else if (ones == 4'd9) begin
                    ones <= 4'd0;
                    tens <= tens + 4'd1;
                end else begin
                    ones <= ones + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_up_counter_2digit.sv
// tb/tb_bcd_up_counter_2digit.sv - randomized check of bcd_up_counter_2digit at TERMINAL 99 and 59
module tb_bcd_up_counter_2digit;

    logic       clk = 1'b0;
    logic       clear;
    logic       enable;
    logic       load;
    logic [7:0] load_value;
    logic [3:0] ones_a, tens_a, ones_b, tens_b;
    logic       carry_a, carry_b, err_a, err_b;

    int total = 0;
    int bad   = 0;

    int term[2] = '{99, 59};
    int cnt[2];
    int car[2];
    int err[2];

    always #5 clk = ~clk;

    bcd_up_counter_2digit #(.TERMINAL(99)) dut_a (
        .clk(clk), .clear(clear), .enable(enable), .load(load), .load_value(load_value),
        .ones(ones_a), .tens(tens_a), .carry(carry_a), .load_err(err_a)
    );

    bcd_up_counter_2digit #(.TERMINAL(59)) dut_b (
        .clk(clk), .clear(clear), .enable(enable), .load(load), .load_value(load_value),
        .ones(ones_b), .tens(tens_b), .carry(carry_b), .load_err(err_b)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            cnt[i] = 0;
            car[i] = 0;
            err[i] = 0;
        end
    endtask

    // Decimal-integer view of the counter: one edge of behaviour per call.
    task automatic model_edge();
        int t, o;
        for (int i = 0; i < 2; i++) begin
            car[i] = 0;
            err[i] = 0;
            if (clear) begin
                cnt[i] = 0;
            end else if (load) begin
                t = int'(load_value) / 16;
                o = int'(load_value) % 16;
                err[i] = (t > 9 || o > 9) ? 1 : 0;
                if (t > 9) t = 0;
                if (o > 9) o = 0;
                cnt[i] = 10 * t + o;
            end else if (enable) begin
                if (cnt[i] >= term[i]) begin
                    cnt[i] = 0;
                    car[i] = 1;
                end else begin
                    cnt[i] = cnt[i] + 1;
                end
            end
        end
    endtask

    task automatic compare(input string tag);
        chk({tag, ".a.ones"},  int'(ones_a),  cnt[0] % 10);
        chk({tag, ".a.tens"},  int'(tens_a),  cnt[0] / 10);
        chk({tag, ".a.carry"}, int'(carry_a), car[0]);
        chk({tag, ".a.err"},   int'(err_a),   err[0]);
        chk({tag, ".b.ones"},  int'(ones_b),  cnt[1] % 10);
        chk({tag, ".b.tens"},  int'(tens_b),  cnt[1] / 10);
        chk({tag, ".b.carry"}, int'(carry_b), car[1]);
        chk({tag, ".b.err"},   int'(err_b),   err[1]);
    endtask

    task automatic step(input string tag, input logic en, input logic ld, input logic [7:0] lv);
        enable     = en;
        load       = ld;
        load_value = lv;
        @(posedge clk);
        model_edge();
        #1;
        compare(tag);
    endtask

    // Raise clear away from any edge and confirm outputs drop without a clock.
    task automatic async_clear(input string tag, input int held_edges);
        #3;
        clear = 1'b1;
        model_clear();
        #1;
        compare({tag, ".async"});
        for (int k = 0; k < held_edges; k++) step({tag, ".held"}, 1'b1, (k % 2) == 1, 8'h55);
        clear = 1'b0;
    endtask

    initial begin
        clear      = 1'b1;
        enable     = 1'b0;
        load       = 1'b0;
        load_value = 8'h00;
        model_clear();
        #1;
        compare("reset");
        @(negedge clk);
        clear = 1'b0;

        for (int k = 0; k < 100; k++) step("run100", 1'b1, 1'b0, 8'h00);

        step("ld37", 1'b0, 1'b1, 8'h37);
        step("ld82_en", 1'b1, 1'b1, 8'h82);
        step("ld5C", 1'b0, 1'b1, 8'h5C);
        step("hold_err", 1'b0, 1'b0, 8'h00);
        step("ldF3", 1'b0, 1'b1, 8'hF3);
        step("ldFF", 1'b1, 1'b1, 8'hFF);

        step("ld45", 1'b0, 1'b1, 8'h45);
        async_clear("clr45", 3);
        step("post_clr", 1'b1, 1'b0, 8'h00);

        step("ld75", 1'b0, 1'b1, 8'h75);
        step("wrap75", 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 5; k++) step("hold5", 1'b0, 1'b0, 8'h00);

        step("ld59", 1'b0, 1'b1, 8'h59);
        step("pend", 1'b1, 1'b0, 8'h00);
        step("ld99", 1'b0, 1'b1, 8'h99);
        enable = 1'b1;
        load   = 1'b0;
        async_clear("clr_carry", 1);

        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_clear("rnd", int'($urandom_range(0, 2)));
            end else begin
                step("rnd", ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                     8'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
